// File: rtl/sb_event_pkg.sv
// sb_event_pkg: shared entry width, tags and volume payload packing for the event queue.
package sb_event_pkg;
  localparam int EV_W = 18;
  localparam logic [1:0] TAG_KEY = 2'b01;
  localparam logic [1:0] TAG_VOL = 2'b10;
  function automatic logic [15:0] vol_payload(input logic muted, input logic [11:0] vol);
    return {muted, 3'b000, vol};
  endfunction
endpackage

// File: rtl/sb_event_fifo.sv
// sb_event_fifo: synchronous FIFO with a registered head entry and occupancy output.
module sb_event_fifo
  import sb_event_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = 4,
  parameter int W = EV_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic          accept,
  output logic [W-1:0]  rdata,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level
);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr, rd, wr_n, rd_n;
  logic do_pop;
  assign empty = wr == rd;
  assign full = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign level = wr - rd;
  assign do_pop = pop & ~empty;
  assign accept = push & (~full | do_pop);
  assign wr_n = wr + {{AW{1'b0}}, accept};
  assign rd_n = rd + {{AW{1'b0}}, do_pop};
  always_ff @(posedge clk)
    if (accept) mem[wr[AW-1:0]] <= wdata;
  // Head is precomputed for the next state so rdata is a plain register.
  always_ff @(posedge clk)
    if (rst) begin
      wr <= '0;
      rd <= '0;
      rdata <= '0;
    end else begin
      wr <= wr_n;
      rd <= rd_n;
      rdata <= (wr_n == rd_n) ? '0 :
               (accept && wr[AW-1:0] == rd_n[AW-1:0]) ? wdata : mem[rd_n[AW-1:0]];
    end
endmodule

// File: rtl/sb_event_queue.sv
// sb_event_queue: merges key and volume events into one tagged FIFO with coalescing
// pending volume register and sticky overflow/drop accounting.
module sb_event_queue
  import sb_event_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic              mon_clk,
  input  logic              reset,
  input  logic [15:0]       latest_keycode,
  input  logic              latest_keycode_valid,
  input  logic              is_muted,
  input  logic [11:0]       volume_db,
  input  logic              volume_db_valid,
  output logic [EV_W-1:0]   ev_data,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [AW:0]       level,
  output logic              overflow,
  output logic [7:0]        drop_count,
  input  logic              overflow_clr
);
  logic pend_vld;
  logic [EV_W-1:0] pend_data, vol_entry, wdata;
  logic push, accept, empty, full, pend_src, load_pend, drop;
  assign vol_entry = {TAG_VOL, vol_payload(is_muted, volume_db)};
  assign ev_valid = ~empty;
  always_comb begin
    push = latest_keycode_valid | pend_vld | volume_db_valid;
    wdata = latest_keycode_valid ? {TAG_KEY, latest_keycode} : pend_vld ? pend_data : vol_entry;
    pend_src = ~latest_keycode_valid & pend_vld;
    load_pend = volume_db_valid & (latest_keycode_valid | pend_vld);
    drop = push & ~accept & ~pend_src;
  end
  sb_event_fifo #(.DEPTH(DEPTH), .AW(AW), .W(EV_W)) u_fifo (
    .clk(mon_clk),
    .rst(reset),
    .push(push),
    .wdata(wdata),
    .pop(ev_ready),
    .accept(accept),
    .rdata(ev_data),
    .empty(empty),
    .full(full),
    .level(level)
  );
  // A blocked pending volume stays put; a newer volume always replaces it.
  always_ff @(posedge mon_clk)
    if (reset) begin
      pend_vld <= 1'b0;
      pend_data <= '0;
      overflow <= 1'b0;
      drop_count <= '0;
    end else begin
      pend_vld <= load_pend | (pend_vld & ~(pend_src & accept));
      if (load_pend) pend_data <= vol_entry;
      overflow <= drop | (overflow & ~overflow_clr);
      drop_count <= drop ? (overflow_clr ? 8'd1 : drop_count + {7'd0, drop_count != 8'hFF}) :
                    overflow_clr ? 8'd0 : drop_count;
    end
endmodule

// File: tb/tb_sb_event_queue.sv
// tb_sb_event_queue: directed and randomized checks against a queue-based reference model.
module tb_sb_event_queue;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  logic mon_clk = 0, reset, latest_keycode_valid, is_muted, volume_db_valid, ev_ready, overflow_clr;
  logic [15:0] latest_keycode;
  logic [11:0] volume_db;
  logic [17:0] ev_data;
  logic ev_valid, overflow;
  logic [AW:0] level;
  logic [7:0] drop_count;
  int errors = 0, checks = 0;
  logic [17:0] q[$];
  bit m_pv, m_ovf;
  logic [17:0] m_pd;
  int m_cnt;

  always #5 mon_clk = ~mon_clk;

  sb_event_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .mon_clk(mon_clk), .reset(reset),
    .latest_keycode(latest_keycode), .latest_keycode_valid(latest_keycode_valid),
    .is_muted(is_muted), .volume_db(volume_db), .volume_db_valid(volume_db_valid),
    .ev_data(ev_data), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .level(level), .overflow(overflow), .drop_count(drop_count), .overflow_clr(overflow_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    latest_keycode_valid = 0; volume_db_valid = 0; overflow_clr = 0;
    latest_keycode = 0; volume_db = 0; is_muted = 0;
  endtask

  task automatic model_step();
    bit room, dropped;
    logic [17:0] vol;
    vol = {2'b10, is_muted, 3'b000, volume_db};
    dropped = 0;
    if (reset) begin
      q.delete(); m_pv = 0; m_pd = 0; m_ovf = 0; m_cnt = 0;
      return;
    end
    room = q.size() < DEPTH || (ev_ready && q.size() > 0);
    if (ev_ready && q.size() > 0) void'(q.pop_front());
    if (latest_keycode_valid) begin
      if (room) q.push_back({2'b01, latest_keycode}); else dropped = 1;
      if (volume_db_valid) begin m_pv = 1; m_pd = vol; end
    end else if (m_pv) begin
      if (room) begin q.push_back(m_pd); m_pv = 0; end
      if (volume_db_valid) begin m_pv = 1; m_pd = vol; end
    end else if (volume_db_valid) begin
      if (room) q.push_back(vol); else dropped = 1;
    end
    if (dropped) begin
      m_ovf = 1;
      m_cnt = overflow_clr ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
    end else if (overflow_clr) begin
      m_ovf = 0; m_cnt = 0;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge mon_clk);
    @(negedge mon_clk);
    chk("ev_valid", ev_valid, q.size() > 0);
    chk("ev_data", ev_data, q.size() > 0 ? q[0] : 18'h0);
    chk("level", level, q.size());
    chk("overflow", overflow, m_ovf);
    chk("drop_count", drop_count, m_cnt);
  endtask

  initial begin
    idle(); ev_ready = 0; reset = 1;
    @(negedge mon_clk);
    step(); step();
    chk("reset_valid", ev_valid, 0);
    chk("reset_level", level, 0);
    reset = 0;
    step(); step(); step();
    latest_keycode = 16'h0A3C; latest_keycode_valid = 1;
    step(); idle();
    chk("key_valid", ev_valid, 1);
    chk("key_data", ev_data, 18'h10A3C);
    chk("key_level", level, 1);
    ev_ready = 1; step(); ev_ready = 0;
    chk("key_popped", ev_valid, 0);
    latest_keycode = 16'h0011; latest_keycode_valid = 1;
    is_muted = 1; volume_db = {6'd5, 6'd7}; volume_db_valid = 1;
    step(); idle(); step();
    chk("pair_level", level, 2);
    chk("pair_head", ev_data, 18'h10011);
    ev_ready = 1; step();
    chk("pair_vol", ev_data, 18'h28147);
    step(); ev_ready = 0;
    for (int i = 0; i < 3; i++) begin
      latest_keycode = 16'h0100 + 16'(i); latest_keycode_valid = 1;
      volume_db = 12'(i); volume_db_valid = 1;
      step();
    end
    idle(); step();
    chk("coal_level", level, 4);
    chk("coal_drops", drop_count, 0);
    chk("coal_head", ev_data, 18'h10100);
    ev_ready = 1; step(); step(); step();
    chk("coal_last_vol", ev_data, 18'h20002);
    step(); ev_ready = 0;
    for (int i = 0; i < 19; i++) begin
      latest_keycode = 16'(i); latest_keycode_valid = 1;
      step();
    end
    chk("fill_level", level, 16);
    chk("fill_ovf", overflow, 1);
    chk("fill_drops", drop_count, 3);
    overflow_clr = 1; step(); overflow_clr = 0;
    chk("clr_drop_cnt", drop_count, 1);
    chk("clr_drop_ovf", overflow, 1);
    ev_ready = 1; latest_keycode = 16'hBEEF; step(); idle();
    chk("fullpp_level", level, 16);
    chk("fullpp_drops", drop_count, 1);
    for (int i = 0; i < 15; i++) step();
    chk("fullpp_last", ev_data, 18'h1BEEF);
    chk("fullpp_lvl1", level, 1);
    step(); ev_ready = 0;
    for (int i = 0; i < 5; i++) begin
      latest_keycode = 16'h0200 + 16'(i); latest_keycode_valid = 1;
      step();
    end
    volume_db_valid = 1; volume_db = 12'hABC; step(); idle();
    reset = 1; step(); reset = 0;
    chk("rst_level", level, 0);
    chk("rst_valid", ev_valid, 0);
    step(); step(); step();
    chk("rst_no_stale", ev_valid, 0);
    for (int i = 0; i < 4000; i++) begin
      latest_keycode_valid = ($urandom % 4) == 0;
      latest_keycode = 16'($urandom);
      volume_db_valid = ($urandom % 3) == 0;
      volume_db = 12'($urandom);
      is_muted = 1'($urandom);
      ev_ready = ((i / 400) % 2 == 0) ? ($urandom % 4 == 0) : ($urandom % 4 != 0);
      overflow_clr = ($urandom % 60) == 0;
      reset = ($urandom % 997) == 0;
      step();
    end
    reset = 0; idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sb_event_queue.md
# sb_event_queue

Buffers user-input events from the NeXT sound box front end (keyboard keycodes, mute/volume updates) into one tagged FIFO. The OSD/CPU side drains the FIFO at its own pace over a valid/ready handshake. The block sits directly downstream of the sound box top and consumes its `latest_keycode*`, `is_muted` and `volume_db*` outputs. Events arrive as single-cycle pulses, so nothing is lost while the consumer is busy, up to `DEPTH` entries.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 4.
- `AW`, 4: log2(`DEPTH`).

- `mon_clk` input 1: sole clock, the monitor-interface clock.
- `reset` input 1: synchronous, active-high.
- `latest_keycode` input 16: keycode, qualified by `latest_keycode_valid`.
- `latest_keycode_valid` input 1: one-cycle key event strobe.
- `is_muted` input 1: mute state, sampled with `volume_db_valid`.
- `volume_db` input 12: {L[5:0], R[5:0]} attenuation, sampled with `volume_db_valid`.
- `volume_db_valid` input 1: one-cycle volume event strobe.
- `ev_data` output 18: head entry {tag[1:0], payload[15:0]}.
- `ev_valid` output 1: FIFO non-empty.
- `ev_ready` input 1: consumer pops the head when `ev_valid` is also high.
- `level` output AW+1: current occupancy, 0..`DEPTH`.
- `overflow` output 1: sticky; set when an event is dropped.
- `drop_count` output 8: saturating count of dropped events.
- `overflow_clr` input 1: clears `overflow` and `drop_count`.

## Operation
- Entry encodings:
  - key: tag 2'b01, payload = `latest_keycode`.
  - volume: tag 2'b10, payload = {`is_muted`, 3'b000, `volume_db`}.
- Push sources, fixed priority: key strobe > pending volume register > new volume strobe.
- Pending volume register (`pend_vld`, `pend_data`):
  - Loaded when `volume_db_valid` cannot be pushed this cycle, i.e. key strobe in the same cycle or `pend_vld` already set.
  - A newer volume event overwrites the pending one (latest wins). Coalescing is not a drop.
  - Pushed on the first cycle with no key strobe.
- Full handling:
  - A push while full and no pop in the same cycle: entry discarded, `overflow` set, `drop_count` incremented (saturates at 255).
  - Pending volume is never discarded by fullness. It waits in the register until space exists.
- Pop: when `ev_valid & ev_ready`, head advances. Push and pop in the same cycle are both honoured, including when full (level unchanged).
- `overflow_clr` and a drop in the same cycle: set wins; `drop_count` becomes 1.
- Pointers are AW+1 bits. Full = MSBs differ and low AW bits equal; empty = pointers equal. Wrap is natural binary.

## Timing
- Reset values:
  - `ev_valid`=0, `level`=0, `overflow`=0, `drop_count`=0.
  - `ev_data`=0.
  - Pointers 0, `pend_vld`=0.
- Reset mid-operation flushes all entries and the pending volume. Strobes in the reset cycle are ignored.
- Latency:
  - Strobe in cycle N to `ev_valid`/`ev_data` in cycle N+1 (FIFO was empty, no conflict).
  - A pending volume is visible one cycle after it is pushed.
- `ev_data` is registered and stable while `ev_valid & !ev_ready`. The next entry appears the cycle after a pop.
- `level` reflects pushes and pops from the previous cycle edge; no combinational path from inputs.
- No combinational path from `ev_ready` to `ev_valid`/`ev_data`.

## Structure
- Package `sb_event_pkg`:
  - `EV_W`=18, `TAG_KEY`=2'b01, `TAG_VOL`=2'b10.
  - Function packing a volume payload.
- Sub-module `sb_event_fifo`: generic synchronous FIFO (`DEPTH`, width `EV_W`, registered head, `level`, full/empty).
- `sb_event_queue` holds push arbitration, the pending register and the overflow/drop logic.

## Test plan
- Reset, then key 16'h0A3C strobe at cycle 5 → cycle 6: `ev_valid`=1, `ev_data`=18'h10A3C, `level`=1. Pop at cycle 7 → `ev_valid`=0.
- Key 16'h0011 and volume (muted, L=6'd5, R=6'd7) in the same cycle, `ev_ready`=0 → entries in order 18'h10011, then 18'h28147; `level`=2 after two cycles.
- Three volume strobes on consecutive cycles, each alongside a key strobe, then idle → 3 key entries plus only the last volume entry; `drop_count`=0.
- Fill 16 keys with `ev_ready`=0, then 3 more keys → `level`=16, `overflow`=1, `drop_count`=3. Pulse `overflow_clr` together with another drop → `drop_count`=1, `overflow`=1.
- Full FIFO with `ev_ready`=1 and a key strobe in the same cycle → `level` stays 16, no drop, new key is the last entry popped.
- Assert `reset` with 5 entries and a pending volume → next cycle `level`=0, `ev_valid`=0; after reset releases, no stale volume entry appears.
